wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Write-back end of the execute-stage result interface (wd/wreg/wdata).
//  Holds the execute result in a one-entry write-back stage register, commits it
//  to a 32-entry general register file, and serves two read ports to decode.
//  Read ports forward the youngest pending result ahead of the array contents.
//  Keeps a counter of committed writes for bring-up and debug.
// PARAMETERS
//  DATA_W   32  register and data width (matches RegBus)
//  ADDR_W   5   register address width (matches RegAddrBus)
//  NREG     32  number of registers; entry 0 is hardwired to zero
//  CNT_W    16  width of the commit counter
// PORTS
//  clk          in   1       clock; all state is updated on the rising edge
//  rst          in   1       asynchronous reset, active-high (RstEnable)
//  wd_i         in   ADDR_W  destination address from execute
//  wreg_i       in   1       execute result has a destination
//  wdata_i      in   DATA_W  execute result value
//  stall_i      in   1       hold the write-back stage register
//  flush_i      in   1       discard the incoming execute result
//  re1_i        in   1       read port 1 enable
//  raddr1_i     in   ADDR_W  read port 1 address
//  rdata1_o     out  DATA_W  read port 1 data (combinational)
//  re2_i        in   1       read port 2 enable
//  raddr2_i     in   ADDR_W  read port 2 address
//  rdata2_o     out  DATA_W  read port 2 data (combinational)
//  wb_wd_o      out  ADDR_W  write-back stage destination address
//  wb_wreg_o    out  1       write-back stage valid-write flag
//  wb_wdata_o   out  DATA_W  write-back stage data
//  commit_cnt_o out  CNT_W   count of committed non-zero-register writes
// BEHAVIOUR
//  Reset (async, rst=1): S = {wb_wd, wb_wreg, wb_wdata} = 0; all NREG entries = 0;
//   commit_cnt_o = 0. Applies immediately, mid-operation included; nothing commits.
//  Commit at each edge with rst=0: when wb_wreg=1, wb_wd!=0 and (stall_i=0 or flush_i=1),
//   reg[wb_wd] <= wb_wdata and commit_cnt_o <= commit_cnt_o+1. The counter wraps
//   from 2^CNT_W-1 to 0.
//  A write to register 0 is dropped and not counted.
//  Stage update at each edge; priority flush > stall > advance:
//   flush_i=1 : S <= 0 (incoming result discarded); the old S still commits.
//   stall_i=1 : S holds, no commit. The entry commits exactly once, on the first
//               non-stalled edge.
//   otherwise : S <= {wd_i, wreg_i, wdata_i}.
//  Latency: execute result -> S 1 edge; S -> array 1 more edge. A read sees the
//   value in the same cycle through forwarding.
//  Read port n (combinational, identical for both ports), first match wins:
//   1. re=0 -> 0
//   2. raddr=0 -> 0
//   3. wreg_i=1, raddr=wd_i and flush_i=0 -> wdata_i
//   4. wb_wreg=1 and raddr=wb_wd -> wb_wdata
//   5. otherwise -> reg[raddr]
//  wb_*_o outputs drive S directly. Both read ports may use the same address.
// TESTING
//  1. Reset: rst=1 mid-run, then read all regs -> 0; commit_cnt_o=0; wb_wreg_o=0.
//  2. Write r5=0x1234_5678: after 2 edges the array holds it and commit_cnt_o=1;
//     reads of r5 return 0x1234_5678 in cycles 0, 1 and 2 (forward paths 3, 4, 5).
//  3. Write r0=0xFFFF_FFFF -> r0 reads 0; commit_cnt_o unchanged.
//  4. Hold stall_i 3 cycles with S={r7,1,0xA5} -> commit_cnt_o rises by 1 only
//     after stall drops; r7 reads 0xA5 throughout.
//  5. flush_i with incoming r3=0x11 while S={r4,1,0x22} -> r4=0x22 committed;
//     r3 never written; wb_wreg_o=0 next cycle.
//  6. Preload commit_cnt_o to 0xFFFF via 65535 writes, one more write -> 0x0000.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage register, 32-entry register file with two forwarding read ports,
// and a wrapping counter of committed writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [CNT_W-1:0]  commit_cnt_o
);

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic [CNT_W-1:0]  commit_cnt;
    logic              commit;

    // A stalled entry waits; a flush still lets the older entry retire.
    assign commit = wb_wreg && (wb_wd != '0) && (int'(wb_wd) < NREG)
                    && (!stall_i || flush_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd      <= '0;
            wb_wreg    <= 1'b0;
            wb_wdata   <= '0;
            commit_cnt <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit) begin
                regs[wb_wd] <= wb_wdata;
                commit_cnt  <= commit_cnt + CNT_W'(1);
            end
            if (flush_i) begin
                wb_wd    <= '0;
                wb_wreg  <= 1'b0;
                wb_wdata <= '0;
            end else if (!stall_i) begin
                wb_wd    <= wd_i;
                wb_wreg  <= wreg_i;
                wb_wdata <= wdata_i;
            end
        end
    end

    // Youngest value wins: execute result, then the stage register, then the array.
    function automatic logic [DATA_W-1:0] read_port(input logic re,
                                                    input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!re || raddr == '0) begin
            val = '0;
        end else if (wreg_i && raddr == wd_i && !flush_i) begin
            val = wdata_i;
        end else if (wb_wreg && raddr == wb_wd) begin
            val = wb_wdata;
        end else if (int'(raddr) < NREG) begin
            val = regs[raddr];
        end
        return val;
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i);
        rdata2_o = read_port(re2_i, raddr2_i);
    end

    assign wb_wd_o      = wb_wd;
    assign wb_wreg_o    = wb_wreg;
    assign wb_wdata_o   = wb_wdata;
    assign commit_cnt_o = commit_cnt;

endmodule
